// File: rtl/sfx_pkg.sv
// Shared types and helpers for the multi-channel sound-effect player.
package sfx_pkg;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_ACC, S_OUT} sfx_state_e;

  // Accumulator width: NUM_CH full-scale samples summed without overflow.
  function automatic int acc_w(input int sample_w, input int num_ch);
    return sample_w + $clog2(num_ch);
  endfunction

  function automatic longint sat_max(input int sample_w);
    return (64'sd1 <<< (sample_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int sample_w);
    return -(64'sd1 <<< (sample_w - 1));
  endfunction

  // LSB position of channel ch's field in a flat per-channel vector.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/sfx_channel_ctrl.sv
// Per-channel playback state: pending trigger, active flag and sample pointer.
module sfx_channel_ctrl
  import sfx_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_trigger,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_slot_addr,
  input  logic              i_slot_acc,
  output logic              o_start,
  output logic              o_active,
  output logic [ADDR_W-1:0] o_ptr
);

  logic              r_pend;
  logic              r_active;
  logic [ADDR_W-1:0] r_ptr;
  logic              w_last;

  // A stop in the same cycle as the slot suppresses the start.
  assign o_start  = i_slot_addr && r_pend && (i_len != '0) && !i_stop;
  assign w_last   = (r_ptr == i_len - 1'b1);
  assign o_active = r_active;
  assign o_ptr    = r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend   <= 1'b0;
      r_active <= 1'b0;
      r_ptr    <= '0;
    end else begin
      // A trigger landing on the start cycle re-arms for the next period.
      if (i_stop)         r_pend <= 1'b0;
      else if (i_trigger) r_pend <= 1'b1;
      else if (o_start)   r_pend <= 1'b0;

      if (i_stop) begin
        r_active <= 1'b0;
      end else if (o_start) begin
        r_active <= 1'b1;
        r_ptr    <= '0;
      end else if (i_slot_acc && r_active) begin
        if (w_last) begin
          if (i_loop) r_ptr    <= '0;
          else        r_active <= 1'b0;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sfx_player_mixer.sv
// Multi-channel clip player/mixer sharing one ROM port; per-channel attenuation
// is available when SFX_VOLUME_EN is defined.
module sfx_player_mixer
  import sfx_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 15,
  parameter int ROM_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_req,
  input  logic [NUM_CH-1:0]        trigger,
  input  logic [NUM_CH-1:0]        stop,
  input  logic [NUM_CH-1:0]        loop_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
`ifdef SFX_VOLUME_EN
  input  logic [NUM_CH*4-1:0]      ch_atten,
`endif
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [SAMPLE_W-1:0]      rom_q,
  output logic [SAMPLE_W-1:0]      audio_output,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        ch_active,
  output logic                     overrun
);

  localparam int ACC_W = acc_w(SAMPLE_W, NUM_CH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [ACC_W-1:0]    ACC_HI = ACC_W'(sat_max(SAMPLE_W));
  localparam logic signed [ACC_W-1:0]    ACC_LO = ACC_W'(sat_min(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] OUT_HI = SAMPLE_W'(sat_max(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] OUT_LO = SAMPLE_W'(sat_min(SAMPLE_W));

  sfx_state_e              r_state;
  logic [CH_W-1:0]         r_ch;
  logic [7:0]              r_wait;
  logic                    r_play;
  logic signed [ACC_W-1:0] r_acc;
  logic [SAMPLE_W-1:0]     r_out;
  logic                    r_vld;
  logic                    r_overrun;

  logic [NUM_CH-1:0]              w_slot_addr, w_slot_acc, w_start, w_active;
  logic [NUM_CH-1:0][ADDR_W-1:0]  w_ptr, w_base;
  logic [NUM_CH-1:0][3:0]         w_atten;
  logic                           w_sel_play;
  logic [ADDR_W-1:0]              w_sel_addr;
  logic [3:0]                     w_shift;
  logic signed [SAMPLE_W-1:0]     w_samp, w_sat;
  logic signed [ACC_W-1:0]        w_contrib, w_acc_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_slot_addr[g] = (r_state == S_ADDR) && (r_ch == CH_W'(g));
    assign w_slot_acc[g]  = (r_state == S_ACC)  && (r_ch == CH_W'(g));
    assign w_base[g]      = ch_base[ch_lsb(g, ADDR_W) +: ADDR_W];
`ifdef SFX_VOLUME_EN
    assign w_atten[g]     = ch_atten[ch_lsb(g, 4) +: 4];
`else
    assign w_atten[g]     = 4'd0;
`endif

    sfx_channel_ctrl #(.ADDR_W(ADDR_W)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_trigger  (trigger[g]),
      .i_stop     (stop[g]),
      .i_loop     (loop_en[g]),
      .i_len      (ch_len[ch_lsb(g, ADDR_W) +: ADDR_W]),
      .i_slot_addr(w_slot_addr[g]),
      .i_slot_acc (w_slot_acc[g]),
      .o_start    (w_start[g]),
      .o_active   (w_active[g]),
      .o_ptr      (w_ptr[g])
    );
  end

  // A channel starting this slot reads sample 0 even though its ptr register
  // has not been cleared yet.
  assign w_sel_play = w_start[r_ch] | w_active[r_ch];
  assign w_sel_addr = w_base[r_ch] + (w_start[r_ch] ? '0 : w_ptr[r_ch]);
  assign rom_addr   = ((r_state == S_ADDR) && w_sel_play) ? w_sel_addr : '0;

  assign w_shift    = w_atten[r_ch];
  assign w_samp     = $signed(rom_q) >>> w_shift;
  assign w_contrib  = r_play ? ACC_W'(w_samp) : '0;
  assign w_acc_next = r_acc + w_contrib;

  always_comb begin
    w_sat = w_acc_next[SAMPLE_W-1:0];
    if (w_acc_next > ACC_HI)      w_sat = OUT_HI;
    else if (w_acc_next < ACC_LO) w_sat = OUT_LO;
  end

  // The mix is registered on the last ACC so out_valid is visible in OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_wait    <= '0;
      r_play    <= 1'b0;
      r_acc     <= '0;
      r_out     <= '0;
      r_vld     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (sample_req && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (sample_req) begin
          r_state <= S_ADDR;
          r_ch    <= '0;
          r_acc   <= '0;
        end
        S_ADDR: begin
          r_play  <= w_sel_play;
          r_wait  <= '0;
          r_state <= (ROM_LAT > 1) ? S_WAIT : S_ACC;
        end
        S_WAIT: begin
          if (r_wait == 8'(ROM_LAT - 2)) r_state <= S_ACC;
          else                           r_wait  <= r_wait + 1'b1;
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          if (r_ch == CH_W'(NUM_CH - 1)) begin
            r_out   <= w_sat;
            r_vld   <= 1'b1;
            r_state <= S_OUT;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_OUT:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign audio_output = r_out;
  assign out_valid    = r_vld;
  assign ch_active    = w_active;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sfx_player_mixer.sv
// Self-checking bench: directed clip scenarios plus randomized periods against a behavioural model.
module tb_sfx_player_mixer;
  localparam int NUM_CH = 4, SAMPLE_W = 16, ADDR_W = 15, ROM_LAT = 1;
  localparam int ROM_N = 1 << ADDR_W;
  localparam int LAT = NUM_CH * (ROM_LAT + 1) + 1;

  logic clk = 1'b0, reset_n = 1'b0, sample_req = 1'b0;
  logic [NUM_CH-1:0] trigger = '0, stop = '0, loop_en = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_base = '0, ch_len = '0;
`ifdef SFX_VOLUME_EN
  logic [NUM_CH*4-1:0] ch_atten = '0;
`endif
  logic [ADDR_W-1:0]   rom_addr;
  logic [SAMPLE_W-1:0] rom_q, audio_output;
  logic                out_valid, overrun;
  logic [NUM_CH-1:0]   ch_active;

  logic [SAMPLE_W-1:0] rom [ROM_N];
  always_ff @(posedge clk) rom_q <= rom[rom_addr];
  always #5 clk = ~clk;

  sfx_player_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .sample_req(sample_req),
    .trigger(trigger), .stop(stop), .loop_en(loop_en),
    .ch_base(ch_base), .ch_len(ch_len),
`ifdef SFX_VOLUME_EN
    .ch_atten(ch_atten),
`endif
    .rom_addr(rom_addr), .rom_q(rom_q), .audio_output(audio_output),
    .out_valid(out_valid), .ch_active(ch_active), .overrun(overrun)
  );

  int nchk = 0, nerr = 0;
  int m_base[NUM_CH], m_len[NUM_CH], m_ptr[NUM_CH];
  bit m_pend[NUM_CH], m_act[NUM_CH];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_act_vec();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_act[i];
    return v;
  endfunction

  // One sample period in the abstract: each channel plays its next clip sample.
  function automatic logic [SAMPLE_W-1:0] model_sample();
    int s;
    logic [SAMPLE_W-1:0] r;
    s = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_pend[i] && m_len[i] != 0) begin
        m_pend[i] = 0; m_act[i] = 1; m_ptr[i] = 0;
      end
      if (m_act[i]) begin
        s += int'($signed(rom[(m_base[i] + m_ptr[i]) % ROM_N]));
        if (m_ptr[i] == m_len[i] - 1) begin
          if (loop_en[i]) m_ptr[i] = 0; else m_act[i] = 0;
        end else m_ptr[i]++;
      end
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    r = s[15:0];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = 0; m_act[i] = 0; m_ptr[i] = 0;
    end
  endfunction

  task automatic cfg(input int ch, input int base, input int len);
    m_base[ch] = base; m_len[ch] = len;
    ch_base[ch*ADDR_W +: ADDR_W] = ADDR_W'(base);
    ch_len[ch*ADDR_W +: ADDR_W]  = ADDR_W'(len);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] trg, input logic [NUM_CH-1:0] stp);
    @(negedge clk);
    trigger = trg; stop = stp;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stp[i]) begin m_pend[i] = 0; m_act[i] = 0; end
      else if (trg[i]) m_pend[i] = 1;
    end
    @(negedge clk);
    trigger = '0; stop = '0;
  endtask

  task automatic do_sample(output logic [SAMPLE_W-1:0] got);
    logic [SAMPLE_W-1:0] exp;
    int n;
    bit seen;
    exp = model_sample();
    @(negedge clk);
    sample_req = 1'b1; n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) sample_req = 1'b0;
      if (out_valid) seen = 1;
    end
    sample_req = 1'b0;
    chk("out_valid_seen", 32'(seen), 32'd1);
    chk("latency", n, LAT);
    chk("audio", 32'(audio_output), 32'(exp));
    chk("ch_active", 32'(ch_active), 32'(m_act_vec()));
    got = audio_output;
    @(negedge clk);
    chk("out_valid_pulse", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SAMPLE_W-1:0] got, exp;
    logic [SAMPLE_W-1:0] exp_os [6];
    logic [SAMPLE_W-1:0] exp_lp [5];
    int nv;
    exp_os = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0};
    exp_lp = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2};
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < NUM_CH; i++) cfg(i, 0, 0);
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_audio", 32'(audio_output), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_active", 32'(ch_active), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // One-shot clip
    rom[100] = 16'd10; rom[101] = 16'd20; rom[102] = 16'd30; rom[103] = 16'd40;
    cfg(0, 100, 4);
    pulse(4'b0001, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      do_sample(got);
      chk("oneshot_val", 32'(got), 32'(exp_os[k]));
      if (k == 2) chk("oneshot_act_hi", 32'(ch_active[0]), 1);
      if (k == 3) chk("oneshot_act_lo", 32'(ch_active[0]), 0);
    end

    // Looping clip with retrigger mid-clip
    rom[200] = 16'd1; rom[201] = 16'd2; rom[202] = 16'd3;
    cfg(1, 200, 3);
    loop_en = 4'b0010;
    pulse(4'b0010, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      do_sample(got);
      chk("loop_val", 32'(got), 32'(exp_lp[k]));
    end
    pulse(4'b0010, 4'b0000);
    do_sample(got);
    chk("retrigger_val", 32'(got), 32'd1);
    pulse(4'b0000, 4'b1111);

    // Saturation both directions
    rom[300] = 16'h7000; rom[301] = 16'h9000;
    cfg(0, 300, 2); cfg(1, 300, 2); cfg(2, 300, 2);
    loop_en = 4'b0111;
    pulse(4'b0111, 4'b0000);
    do_sample(got);
    chk("sat_pos", 32'(got), 32'h7FFF);
    do_sample(got);
    chk("sat_neg", 32'(got), 32'h8000);
    pulse(4'b0000, 4'b1111);

    // Stop and trigger in the same cycle
    pulse(4'b0100, 4'b0100);
    do_sample(got);
    chk("collide_val", 32'(got), 32'd0);
    chk("collide_act", 32'(ch_active[2]), 0);

    // Randomized periods, including address wrap near the top of the ROM
    for (int it = 0; it < 60; it++) begin
      logic [NUM_CH-1:0] trg, stp;
      for (int i = 0; i < NUM_CH; i++)
        if (!m_act[i] && !m_pend[i] && ($urandom % 3 == 0))
          cfg(i, ($urandom % 4 == 0) ? $urandom_range(ROM_N - 4, ROM_N - 1) : $urandom_range(0, ROM_N - 1),
              $urandom_range(0, 6));
      loop_en = NUM_CH'($urandom);
      trg = NUM_CH'($urandom & $urandom);
      stp = ($urandom % 6 == 0) ? NUM_CH'(1 << $urandom_range(0, NUM_CH - 1)) : '0;
      if (trg != 0 || stp != 0) pulse(trg, stp);
      do_sample(got);
    end
    pulse(4'b0000, 4'b1111);

    // Overrun: second request two cycles into a period
    chk("overrun_pre", 32'(overrun), 0);
    exp = model_sample();
    nv = 0;
    @(negedge clk); sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    @(negedge clk); sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        nv++;
        chk("overrun_audio", 32'(audio_output), 32'(exp));
      end
    end
    chk("overrun_pulses", nv, 1);
    chk("overrun_set", 32'(overrun), 1);
    repeat (5) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 1);

    // Asynchronous reset in the middle of ACC
    rom[400] = 16'h1234;
    cfg(0, 400, 1);
    loop_en = 4'b0001;
    pulse(4'b0001, 4'b0000);
    do_sample(got);
    chk("pre_reset_val", 32'(got), 32'h1234);
    @(negedge clk); sample_req = 1'b1;
    @(negedge clk); sample_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_audio", 32'(audio_output), 0);
    chk("arst_active", 32'(ch_active), 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_rom_addr", 32'(rom_addr), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_sample(got);
    chk("post_reset_val", 32'(got), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
